// File: rtl/key_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : key_pkg
// Purpose  : Shared widths and FSM state encoding for the key sink.
// Revision : 1.0 - initial release
// ============================================================================
package key_pkg;

    localparam int KEY_W         = 256;
    localparam int WORD_W        = 32;
    localparam int IDX_W         = 6;
    localparam int WORDS_PER_KEY = KEY_W / WORD_W;

    typedef enum logic [1:0] {
        WAIT_KEY = 2'd0,
        STREAM   = 2'd1,
        HOLD     = 2'd2,
        RELEASE  = 2'd3
    } key_state_t;

endpackage
`default_nettype wire

// File: rtl/key_word_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : key_word_serializer
// Purpose  : Holds one key and presents it MSW-first on a valid/ready port.
//            KEY_ZEROIZE_EN clears the key and data after the final word.
// Revision : 1.0 - initial release
// ============================================================================
module key_word_serializer #(
    parameter int KEY_W  = 256,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [KEY_W-1:0]  key_in,
    output logic [WORD_W-1:0] word_data,
    output logic              word_valid,
    output logic              word_last,
    input  logic              word_ready,
    output logic              last_xfer
);

    localparam int WORDS  = KEY_W / WORD_W;
    localparam int WIDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(WORDS - 1);

    logic [KEY_W-1:0]  r_key;
    logic [WIDX_W-1:0] r_idx;
    logic [WORD_W-1:0] r_data;
    logic              r_valid;
    logic              r_last;

    logic              w_xfer;
    logic [WIDX_W-1:0] w_idx_nxt;
    logic [KEY_W-1:0]  w_shifted;

    assign w_xfer    = r_valid & word_ready;
    assign w_idx_nxt = r_idx + 1'b1;
    // Next word is pre-selected so the register can reload every cycle (no bubbles).
    assign w_shifted = r_key << (int'(w_idx_nxt) * WORD_W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key   <= '0;
            r_idx   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (load) begin
            r_key   <= key_in;
            r_idx   <= '0;
            r_data  <= key_in[KEY_W-1 -: WORD_W];
            r_valid <= 1'b1;
            r_last  <= (WORDS == 1);
        end else if (w_xfer) begin
            if (r_last) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
`ifdef KEY_ZEROIZE_EN
                r_key   <= '0;
                r_data  <= '0;
`endif
            end else begin
                r_idx   <= w_idx_nxt;
                r_data  <= w_shifted[KEY_W-1 -: WORD_W];
                r_last  <= (w_idx_nxt == LAST_IDX);
            end
        end
    end

    assign word_data  = r_data;
    assign word_valid = r_valid;
    assign word_last  = r_last;
    assign last_xfer  = w_xfer & r_last;

endmodule
`default_nettype wire

// File: rtl/key_sink_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : key_sink_ctrl
// Purpose  : Captures a key from the generator, streams it downstream and
//            handshakes top_ready for the next one. Option: KEY_ZEROIZE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module key_sink_ctrl #(
    parameter int KEY_W  = key_pkg::KEY_W,
    parameter int WORD_W = key_pkg::WORD_W,
    parameter int IDX_W  = key_pkg::IDX_W
) (
    input  logic              key_clk,
    input  logic              key_reset_n,
    input  logic [KEY_W-1:0]  private_key,
    input  logic              private_key_valid,
    output logic              top_ready,
    output logic [WORD_W-1:0] key_word_data,
    output logic              key_word_valid,
    input  logic              key_word_ready,
    output logic              key_word_last,
    input  logic              next_req,
    output logic [IDX_W-1:0]  key_count,
    output logic              busy
);

    import key_pkg::*;

    key_state_t       r_state;
    key_state_t       w_state_nxt;
    logic             w_capture;
    logic             w_last_xfer;
    logic             r_pend;
    logic             r_top_ready;
    logic             r_busy;
    logic [IDX_W-1:0] r_count;

    key_word_serializer #(
        .KEY_W  (KEY_W),
        .WORD_W (WORD_W)
    ) u_ser (
        .clk        (key_clk),
        .rst_n      (key_reset_n),
        .load       (w_capture),
        .key_in     (private_key),
        .word_data  (key_word_data),
        .word_valid (key_word_valid),
        .word_last  (key_word_last),
        .word_ready (key_word_ready),
        .last_xfer  (w_last_xfer)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        case (r_state)
            WAIT_KEY: begin
                if (private_key_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (w_last_xfer) begin
                    w_state_nxt = (r_pend || next_req) ? RELEASE : HOLD;
                end
            end
            HOLD: begin
                if (next_req) begin
                    w_state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                w_state_nxt = WAIT_KEY;
            end
            default: begin
                w_state_nxt = WAIT_KEY;
            end
        endcase
    end

    // Status outputs are computed from the next state so they line up with it.
    always_ff @(posedge key_clk or negedge key_reset_n) begin
        if (!key_reset_n) begin
            r_state     <= WAIT_KEY;
            r_pend      <= 1'b0;
            r_top_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_count     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_top_ready <= (w_state_nxt == STREAM) || (w_state_nxt == HOLD);
            r_busy      <= (w_state_nxt != WAIT_KEY);
            if (w_capture) begin
                r_count <= r_count + 1'b1;
            end
            if (w_state_nxt == RELEASE) begin
                r_pend <= 1'b0;
            end else if ((r_state == STREAM) && next_req) begin
                r_pend <= 1'b1;
            end
        end
    end

    assign top_ready = r_top_ready;
    assign busy      = r_busy;
    assign key_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_key_sink_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_key_sink_ctrl
// Purpose  : Self-checking bench for key_sink_ctrl against a word-list model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_sink_ctrl;

    import key_pkg::*;

    localparam int NW = WORDS_PER_KEY;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [KEY_W-1:0]  private_key;
    logic              pkv;
    logic              top_ready;
    logic [WORD_W-1:0] kdata;
    logic              kvalid;
    logic              kready;
    logic              klast;
    logic              next_req;
    logic [IDX_W-1:0]  key_count;
    logic              busy;

    int tests       = 0;
    int failed      = 0;
    int model_count = 0;

    key_sink_ctrl dut (
        .key_clk           (clk),
        .key_reset_n       (rst_n),
        .private_key       (private_key),
        .private_key_valid (pkv),
        .top_ready         (top_ready),
        .key_word_data     (kdata),
        .key_word_valid    (kvalid),
        .key_word_ready    (kready),
        .key_word_last     (klast),
        .next_req          (next_req),
        .key_count         (key_count),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [KEY_W-1:0] obs, input logic [KEY_W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WORD_W-1:0] word_of(input logic [KEY_W-1:0] k, input int i);
        logic [KEY_W-1:0] s;
        s = k >> (WORD_W * (NW - 1 - i));
        return s[WORD_W-1:0];
    endfunction

    function automatic logic [KEY_W-1:0] rand_key();
        logic [KEY_W-1:0] k = '0;
        for (int j = 0; j < NW; j++) begin
            k = (k << WORD_W) | KEY_W'($urandom());
        end
        return k;
    endfunction

    // stall_mode: 0 always ready, 1 pattern 1,0,0, 2 random.
    // req_word: word whose handshake also carries next_req (-1: none, HOLD until later).
    task automatic deliver(input logic [KEY_W-1:0] key, input int valid_cycles,
                           input int stall_mode, input int req_word);
        int w    = 0;
        int cyc  = 0;
        int high = 0;
        bit rdy;
        private_key = key;
        pkv         = 1'b1;
        step();
        model_count = (model_count + 1) % (1 << IDX_W);
        check("cap_top_ready", KEY_W'(top_ready), KEY_W'(1));
        check("cap_count", KEY_W'(key_count), KEY_W'(model_count));
        check("cap_busy", KEY_W'(busy), KEY_W'(1));
        while (w < NW && cyc < 200) begin
            if (top_ready) high++;
            pkv = (cyc + 1 < valid_cycles);
            case (stall_mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            kready   = rdy;
            next_req = rdy && (w == req_word);
            check("word_valid", KEY_W'(kvalid), KEY_W'(1));
            check("word_data", KEY_W'(kdata), KEY_W'(word_of(key, w)));
            check("word_last", KEY_W'(klast), KEY_W'(w == NW - 1));
            if (rdy) w++;
            cyc++;
            step();
        end
        check("all_words_delivered", KEY_W'(w), KEY_W'(NW));
        if (stall_mode == 0) check("zero_bubble_cycles", KEY_W'(cyc), KEY_W'(NW));
        kready   = 1'b0;
        next_req = 1'b0;
        pkv      = 1'b0;
        check("post_valid_low", KEY_W'(kvalid), KEY_W'(0));
        check("post_last_low", KEY_W'(klast), KEY_W'(0));
        check("no_second_capture", KEY_W'(key_count), KEY_W'(model_count));
`ifdef KEY_ZEROIZE_EN
        check("zeroized_data", KEY_W'(kdata), KEY_W'(0));
        check("zeroized_key", dut.u_ser.r_key, KEY_W'(0));
`else
        check("retained_data", KEY_W'(kdata), KEY_W'(word_of(key, NW - 1)));
        check("retained_key", dut.u_ser.r_key, key);
`endif
        if (req_word < 0) begin
            repeat ($urandom_range(1, 3)) begin
                check("hold_top_ready", KEY_W'(top_ready), KEY_W'(1));
                check("hold_busy", KEY_W'(busy), KEY_W'(1));
                if (top_ready) high++;
                step();
            end
            if (top_ready) high++;
            next_req = 1'b1;
            step();
            next_req = 1'b0;
        end
        check("release_top_ready", KEY_W'(top_ready), KEY_W'(0));
        check("release_busy", KEY_W'(busy), KEY_W'(1));
        check("ready_high_time", KEY_W'(high >= NW), KEY_W'(1));
        private_key = ~key;
        pkv         = 1'b1;
        step();
        pkv = 1'b0;
        check("wait_busy_low", KEY_W'(busy), KEY_W'(0));
        check("wait_top_ready_low", KEY_W'(top_ready), KEY_W'(0));
        check("release_ignores_valid", KEY_W'(key_count), KEY_W'(model_count));
    endtask

    initial begin
        logic [KEY_W-1:0] k;
        logic [KEY_W-1:0] first_key;
        rst_n       = 1'b0;
        pkv         = 1'b0;
        kready      = 1'b0;
        next_req    = 1'b0;
        private_key = '0;
        step();
        step();
        check("rst_top_ready", KEY_W'(top_ready), KEY_W'(0));
        check("rst_valid", KEY_W'(kvalid), KEY_W'(0));
        check("rst_last", KEY_W'(klast), KEY_W'(0));
        check("rst_data", KEY_W'(kdata), KEY_W'(0));
        check("rst_count", KEY_W'(key_count), KEY_W'(0));
        check("rst_busy", KEY_W'(busy), KEY_W'(0));
        rst_n = 1'b1;
        step();
        check("idle_no_capture", KEY_W'(key_count), KEY_W'(0));

        // Known key, valid held two cycles, downstream always ready
        k = {32'hebcdf67a, 32'h01234567, 32'h89abcdef, 32'hdeadbeef,
             32'h0badf00d, 32'h13579bdf, 32'h2468ace0, 32'ha71a859f};
        deliver(k, 2, 0, -1);
        deliver(rand_key(), 1, 1, -1);
        deliver(rand_key(), 1, 0, 3);
        deliver(rand_key(), 3, 2, NW - 1);

        // Asynchronous reset while word 3 is presented
        k           = rand_key();
        private_key = k;
        pkv         = 1'b1;
        step();
        pkv    = 1'b0;
        kready = 1'b1;
        repeat (3) step();
        check("pre_reset_word3", KEY_W'(kdata), KEY_W'(word_of(k, 3)));
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", KEY_W'(kvalid), KEY_W'(0));
        check("async_rst_data", KEY_W'(kdata), KEY_W'(0));
        check("async_rst_top_ready", KEY_W'(top_ready), KEY_W'(0));
        check("async_rst_count", KEY_W'(key_count), KEY_W'(0));
        check("async_rst_busy", KEY_W'(busy), KEY_W'(0));
        kready = 1'b0;
        step();
        rst_n       = 1'b1;
        model_count = 0;
        step();

        // 65 keys after reset: counter wraps 63 -> 0 -> 1
        first_key = rand_key();
        deliver(first_key, 1, 0, -1);
        for (int n = 1; n < 64; n++) begin
            deliver(rand_key(), int'($urandom_range(1, 3)), 2,
                    ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, NW - 1)) : -1);
        end
        check("wrap_to_zero", KEY_W'(key_count), KEY_W'(0));
        deliver(first_key, 1, 0, 5);
        check("wrap_to_one", KEY_W'(key_count), KEY_W'(1));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/key_sink_ctrl.md
Name: key_sink_ctrl

Overview:
- Consumer end of the private-key handshake. Captures one 256-bit key from the key generator on `private_key_valid`.
- Streams the captured key downstream (scalar-multiply / PS bridge) as 32-bit words over a valid/ready interface.
- Drives `top_ready` high→low back to the generator to request the next key.
- Sits between the key generator and the crypto datapath.

Parameters:
- KEY_W, 256, key width in bits; must be a multiple of WORD_W
- WORD_W, 32, downstream word width
- IDX_W, 6, width of the received-key counter (wraps at 2^IDX_W)

Ports:
- key_clk  in  1  clock
- key_reset_n  in  1  reset; one clock, asynchronous, active-low
- private_key  in  KEY_W  key from generator, valid when private_key_valid=1
- private_key_valid  in  1  key strobe; may stay high several consecutive cycles with the same key
- top_ready  out  1  busy/ack to generator; its falling edge requests the next key
- key_word_data  out  WORD_W  current key word, most-significant word first
- key_word_valid  out  1  word available
- key_word_ready  in  1  downstream accepts word
- key_word_last  out  1  high with the final word (index KEY_W/WORD_W-1)
- next_req  in  1  single-cycle pulse: downstream finished with key, fetch next
- key_count  out  IDX_W  number of keys captured, modulo 2^IDX_W
- busy  out  1  high in any state other than WAIT_KEY

Behaviour:
- Reset (async, key_reset_n=0) clears everything:
  - top_ready=0, key_word_valid=0, key_word_last=0, key_word_data=0, key_count=0, busy=0
  - state=WAIT_KEY, key register=0, word index=0, pending-request flag=0
- All outputs are registered.
- WAIT_KEY:
  - On a clock edge with private_key_valid=1: latch private_key, key_count+1, word index=0, go to STREAM.
  - The next cycle shows top_ready=1 and key_word_valid=1 with word 0 = key[KEY_W-1 -: WORD_W].
  - Capture latency is 1 cycle.
- STREAM:
  - A word transfers on a cycle where key_word_valid & key_word_ready are both high; the next word is presented the following cycle.
  - Data and last are held stable while ready=0; zero-bubble streaming is required (N words in N cycles when ready stays high).
  - The last handshake goes to HOLD, or directly to RELEASE if the pending-request flag is set. key_word_valid drops the next cycle.
- HOLD: top_ready=1; next_req=1 → RELEASE.
- RELEASE:
  - top_ready=0 for exactly one cycle, then WAIT_KEY.
  - private_key_valid is ignored in RELEASE.
- private_key_valid is ignored outside WAIT_KEY. Repeated valid cycles carrying an already-captured key never cause a second capture.
- top_ready:
  - Rises the cycle after capture.
  - Stays high through STREAM and HOLD; minimum high time is KEY_W/WORD_W cycles, which satisfies the generator's need to sample it high.
  - Falls upon entering RELEASE.
  - The generator presents the next key ≥2 cycles after the fall.
- next_req in STREAM or WAIT_KEY:
  - In STREAM it sets the pending-request flag, which is cleared on entering RELEASE.
  - In WAIT_KEY it is ignored.
- Simultaneous next_req and last handshake in STREAM: treated as pending → RELEASE.
- key_count wraps 2^IDX_W-1 → 0.
- Reset mid-stream: outputs clear asynchronously. Downstream must discard any partial key. The generator is on its own reset and must be reset together with this block.

Optional Feature:
- KEY_ZEROIZE_EN defined:
  - The key register and key_word_data are forced to 0 on the cycle after the last word handshake.
  - Key material never persists past delivery.
- KEY_ZEROIZE_EN undefined: the key register retains the last key until the next capture.
- No other behaviour differs.

Decomposition:
- Shared package (key_pkg):
  - KEY_W and WORD_W constants
  - WORDS_PER_KEY = KEY_W/WORD_W
  - state enum {WAIT_KEY, STREAM, HOLD, RELEASE}
- One natural sub-module, key_word_serializer: key register + word index + valid/ready output stage. The FSM and generator handshake stay in the top.

Test Plan:
- Reset, then key 0xebcd…859f with valid held 2 cycles, ready=1 → exactly 8 words in 8 consecutive cycles:
  - first word 0xebcdf67a, last word 0xa71a859f with key_word_last=1
  - key_count=1, no second capture
- Downstream ready toggled 1,0,0,1… during STREAM → key_word_data/last stable while stalled, all 8 words delivered in order, none duplicated.
- next_req pulsed mid-stream → after the last handshake, top_ready falls with no HOLD cycle; otherwise HOLD persists until next_req.
- Connect to the real key generator, drain 65 keys → key_count wraps 63→0→1 and the 65th key equals key index 0. top_ready is seen high ≥8 cycles before every fall.
- Assert key_reset_n low during word 3 → all outputs 0 asynchronously (before the next edge); after release, a fresh key is captured normally.
- With KEY_ZEROIZE_EN: after the last handshake, key_word_data=0 and the internal key register=0. Without it, the register holds the last key.
